adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined multi-bit adder built from the team's full-adder equations (Sum = A^B^Cin, Cout = A&B | Cin&(A^B)). Carry propagates across WIDTH/STAGES-bit slices, one slice per register stage. Valid/ready handshakes on input and output let it sit in streaming datapaths. It is the wide, sequential successor to the 1-bit combinational full adder. Optional subtract mode and a signed-overflow flag extend it beyond plain addition.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥1.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0 (violations are a `$error` at elaboration).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in, or borrow-in when Sub=1.
- Sub  input  1  1 = subtract. Present only with ADDER_SUB_EN.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out; in subtract mode, 1 = no borrow.
- Ovf  output  1  two's-complement overflow.
- out_valid  output  1  Sum/Cout/Ovf valid.
- out_ready  input  1  downstream accepts result.

## Operation
- Slice width: W = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k·W +: W] of A and B′ with the carry registered by stage k-1. Stage 0 uses carry-in c0.
- Without subtract: B′ = B, c0 = Cin.
- With subtract: B′ = Sub ? ~B : B, c0 = Sub ? ~Cin : Cin. Result is A + B + Cin, or A − B − Cin.
- Operand slices for stage k are delayed k cycles. Finished lower Sum slices are delayed so that all slices of one transaction emerge together.
- Cout is the carry out of bit WIDTH-1. Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Global-stall pipeline:
  - advance = !out_valid | out_ready; in_ready = advance & !rst.
  - On advance, every stage (data and valid bit) shifts one step, and stage 0 loads the input with valid = in_valid.
  - Without advance, all stages hold.
  - Bubbles are not collapsed.
- A transfer occurs on a rising edge with in_valid & in_ready; a result is consumed on a rising edge with out_valid & out_ready.
- Results are delivered strictly in acceptance order, with no loss and no duplication.
- Operand values presented while in_valid=0 have no effect on any output.

## Timing
- Latency: an operand accepted at edge t gives out_valid=1 after edge t+STAGES-1, when the pipeline is not stalled. For STAGES=1, the result is valid the cycle after acceptance.
- Throughput: one result per cycle while out_ready=1.
- Outputs are registered. Sum, Cout, Ovf and out_valid hold stable while out_valid=1 & out_ready=0.
- in_ready is combinational from out_valid, out_ready and rst. There is no combinational path from A, B or Cin to any output.
- Reset, asynchronous and active-high:
  - All valid bits, Sum, Cout and Ovf go to 0 immediately; out_valid=0, in_ready=0.
  - Transactions in flight are discarded.
  - The first edge after deassertion can accept data.
- Simultaneous accept and consume in the same cycle is legal and sustains full throughput.

## Configuration
- ADDER_SUB_EN:
  - Defined: the Sub port exists and subtract mode operates as above.
  - Undefined: no Sub port, B′ = B and c0 = Cin; add only, with identical timing.

## Test plan
Parameters: WIDTH=16, STAGES=4.
- Single add, A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0; out_valid asserts 3 cycles after the accept edge.
- Signed overflow, A=0x7FFF, B=0x0001, Cin=0 → Sum=0x8000, Cout=0, Ovf=1. Also A=0x1234, B=0x4321, Cin=1 → Sum=0x5556, Cout=0, Ovf=0.
- Stream of 8 random operand pairs on consecutive cycles with out_ready=1 → 8 results on consecutive cycles, in order, each matching the reference model.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles → in_ready=0 and outputs frozen. Release → all results drain in order with none lost or duplicated.
- Subtract (ADDER_SUB_EN):
  - A=0x0005, B=0x0007, Sub=1, Cin=0 → Sum=0xFFFE, Cout=0, Ovf=0.
  - A=0x8000, B=0x0001, Sub=1, Cin=0 → Sum=0x7FFF, Cout=1, Ovf=1.
- Reset mid-operation with 3 transactions in flight → out_valid=0 asynchronously and no stale result ever appears. A new op accepted after reset returns the correct value at normal latency.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry adder with a valid/ready stream interface.
// The carry crosses one WIDTH/STAGES-bit slice per register stage.
//
// Optional feature macro: ADDER_SUB_EN
//   When defined, the Sub port exists and the block can also subtract.
//
// Parameters:
//   WIDTH   operand and result width (at least 1)
//   STAGES  pipeline depth and slice count (WIDTH % STAGES == 0)
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   A, B, Cin             operands and carry-in (borrow-in when Sub=1)
//   Sub                   1 = compute A - B - Cin (ADDER_SUB_EN only)
//   in_valid, in_ready    input handshake
//   Sum, Cout, Ovf        result, carry-out (1 = no borrow), signed overflow
//   out_valid, out_ready  output handshake
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDER_SUB_EN
    input  logic             Sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int W = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
        (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipe: illegal WIDTH/STAGES combination");
    end

    logic             advance;
    logic [WIDTH-1:0] bp;
    logic             c0;
    logic             ovf_q;
    logic             ovf_n;

`ifdef ADDER_SUB_EN
    // A - B - Cin == A + ~B + ~Cin
    assign bp = Sub ? ~B : B;
    assign c0 = Sub ? ~Cin : Cin;
`else
    assign bp = B;
    assign c0 = Cin;
`endif

    // Global stall: everything moves together or nothing moves.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rst;

    // One slice of full adders; returns {carry_out, sum}.
    function automatic logic [W:0] add_slice(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         ci
    );
        logic [W-1:0] s;
        logic         c;
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * W;
        // Operand bits still to be added when entering this stage.
        localparam int PW = WIDTH - LO;

        logic          v;
        logic          c;
        logic [LO+W-1:0] s;

        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        logic          pc;
        logic          pv;
        logic [LO+W-1:0] sn;
        logic [W:0]    r;

        if (k == 0) begin : g_src
            assign pa = A;
            assign pb = bp;
            assign pc = c0;
            assign pv = in_valid;
            assign sn = r[W-1:0];
        end else begin : g_src
            assign pa = stg[k-1].g_rem.ra;
            assign pb = stg[k-1].g_rem.rb;
            assign pc = stg[k-1].c;
            assign pv = stg[k-1].v;
            // Finished lower slices ride along with the transaction.
            assign sn = {r[W-1:0], stg[k-1].s};
        end

        assign r = add_slice(pa[W-1:0], pb[W-1:0], pc);

        // Data only loads behind a valid bit so bubbles leave
        // the last result in place.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
            end else if (advance) begin
                v <= pv;
                if (pv) begin
                    c <= r[W];
                    s <= sn;
                end
            end
        end

        if (PW > W) begin : g_rem
            logic [PW-W-1:0] ra;
            logic [PW-W-1:0] rb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                end else if (advance && pv) begin
                    ra <= pa[PW-1:W];
                    rb <= pb[PW-1:W];
                end
            end
        end
    end

    // Carry into the top bit is recovered from its sum bit:
    // s = a ^ b ^ cin  =>  cin = s ^ a ^ b.
    assign ovf_n = stg[L].pa[W-1] ^ stg[L].pb[W-1] ^
                   stg[L].r[W-1] ^ stg[L].r[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance && stg[L].pv) begin
            ovf_q <= ovf_n;
        end
    end

    assign Sum       = stg[L].s;
    assign Cout      = stg[L].c;
    assign Ovf       = ovf_q;
    assign out_valid = stg[L].v;

endmodule
